// File: rtl/spike_dispatcher_pkg.sv
// spike_dispatcher_pkg: dispatcher FSM state encoding and default address width
package spike_dispatcher_pkg;
  localparam int SPIKE_ADDR_W = 12;
  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, CLEAR} disp_state_t;
endpackage

// File: rtl/spike_fifo.sv
// spike_fifo: spike address queue with push/pop, occupancy count and full/empty flags
// Ports: clk, rst_n (async active-low); push/din write when not full; pop advances head
// when not empty; dout shows the head entry; count, full and empty report occupancy.
module spike_fifo
  import spike_dispatcher_pkg::*;
#(
  parameter int W = SPIKE_ADDR_W,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // pointers are exactly log2(DEPTH) wide so they wrap modulo DEPTH on their own
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/spike_dispatcher.sv
// spike_dispatcher: queues spike addresses, paces them out to the MAC units and sequences timestep clears
// Ports: CLK, RESET_N (async active-low); spike_valid/spike_address/spike_ready upstream handshake;
// timestep_end pulse; source_address/source_valid issue strobe; clear MAC command; busy, fifo_count,
// timestep_count and sticky ts_overrun status.
module spike_dispatcher
  import spike_dispatcher_pkg::*;
#(
  parameter int ADDR_W = SPIKE_ADDR_W,
  parameter int FIFO_DEPTH = 16,
  parameter int DISPATCH_GAP = 2,
  parameter int CLEAR_HOLD = 8,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              spike_valid,
  input  logic [ADDR_W-1:0] spike_address,
  output logic              spike_ready,
  input  logic              timestep_end,
  output logic [ADDR_W-1:0] source_address,
  output logic              source_valid,
  output logic              clear,
  output logic              busy,
  output logic [CW-1:0]     fifo_count,
  output logic [15:0]       timestep_count,
  output logic              ts_overrun
);
  localparam int GW = $clog2(DISPATCH_GAP) + 1;
  localparam int HW = $clog2(CLEAR_HOLD) + 1;
  disp_state_t state, state_n;
  logic pending, push, pop, full, empty, leave, accepting, issuing;
  logic [GW-1:0] gap;
  logic [HW-1:0] hold;
  logic [ADDR_W-1:0] head;
  assign accepting = state == IDLE || state == DISPATCH;
  assign issuing = state == DISPATCH || state == DRAIN;
  // ready is masked by reset so upstream never sees a handshake while held in reset
  assign spike_ready = RESET_N && !full && accepting;
  assign push = spike_valid && spike_ready;
  assign pop = issuing && !empty && gap == '0;
  assign leave = state == CLEAR && hold == HW'(CLEAR_HOLD - 1);
  assign clear = state == CLEAR;
  assign busy = state != IDLE || !empty;
  spike_fifo #(.W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK),
    .rst_n(RESET_N),
    .push(push),
    .pop(pop),
    .din(spike_address),
    .dout(head),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
  // DRAIN leaves only once the queue is empty, i.e. the cycle after the last issue strobe
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DISPATCH: state_n = pending ? DRAIN : empty ? IDLE : DISPATCH;
      DRAIN: state_n = empty ? CLEAR : DRAIN;
      CLEAR: state_n = leave ? IDLE : CLEAR;
      default: state_n = IDLE;
    endcase
  end
  // the gap counter runs in every state so pacing survives a DISPATCH->IDLE->DISPATCH bounce
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= IDLE;
      pending <= 1'b0;
      gap <= '0;
      hold <= '0;
      source_address <= '0;
      source_valid <= 1'b0;
      timestep_count <= '0;
      ts_overrun <= 1'b0;
    end else begin
      state <= state_n;
      pending <= leave ? 1'b0 : (timestep_end && accepting) ? 1'b1 : pending;
      ts_overrun <= ts_overrun || (timestep_end && (pending || !accepting));
      gap <= pop ? GW'(DISPATCH_GAP - 1) : gap != '0 ? gap - 1'b1 : gap;
      hold <= clear ? hold + 1'b1 : '0;
      source_valid <= pop;
      source_address <= pop ? head : source_address;
      timestep_count <= timestep_count + 16'(leave);
    end
endmodule
